// File: rtl/sram_req_arbiter_if.sv
// Requester and downstream LSRAM control signals seen by sram_req_arbiter.
// The slave modport is the arbiter. The master modport drives the requests and the SRAM responses.
interface sram_req_arbiter_if #(
   parameter int MEM_AWIDTH = 19
);
   logic                  req0;
   logic                  req1;
   logic                  write0;
   logic                  write1;
   logic [2:0]            size0;
   logic [2:0]            size1;
   logic [MEM_AWIDTH-1:0] addr0;
   logic [MEM_AWIDTH-1:0] addr1;
   logic [31:0]           wdata0;
   logic [31:0]           wdata1;
   logic                  ack0;
   logic                  ack1;
   logic [31:0]           rdata0;
   logic [31:0]           rdata1;
   logic                  ahbsram_req;
   logic                  ahbsram_write;
   logic [2:0]            ahbsram_size;
   logic [MEM_AWIDTH-1:0] ahbsram_addr;
   logic [31:0]           ahbsram_wdata;
   logic                  sramahb_ack;
   logic [31:0]           sramahb_rdata;

   modport slave (
      input  req0, req1, write0, write1, size0, size1, addr0, addr1, wdata0, wdata1,
      output ack0, ack1, rdata0, rdata1,
      output ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
      input  sramahb_ack, sramahb_rdata
   );

   modport master (
      output req0, req1, write0, write1, size0, size1, addr0, addr1, wdata0, wdata1,
      input  ack0, ack1, rdata0, rdata1,
      input  ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
      output sramahb_ack, sramahb_rdata
   );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-port arbiter/sequencer in front of the LSRAM control interface. Round-robin by default.
// Defining SRAM_ARB_FIXED_PRIO_EN makes port 0 win every contention.
//
// state | meaning
// IDLE  | waiting for req0/req1; the winner's command is latched on the way out
// ISSUE | single-cycle ahbsram_req with the latched command
// WAIT  | holds the command until sramahb_ack
// RESP  | one-cycle ack (and read data) to the granted port
module sram_req_arbiter #(
   parameter int MEM_AWIDTH = 19
) (
   input  logic                HCLK,
   input  logic                aresetn,
   sram_req_arbiter_if.slave   bus,
   output logic                grant,
   output logic                arb_busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  grant_q;
   logic                  last_grant_q;
   logic                  win;
   logic                  any_req;
   logic                  write_q;
   logic [2:0]            size_q;
   logic [MEM_AWIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;

   assign any_req = bus.req0 | bus.req1;

   always_comb begin
      win = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      win = ~bus.req0;
`else
      if (bus.req0 && bus.req1)
         win = ~last_grant_q;
      else
         win = ~bus.req0;
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (bus.sramahb_ack) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         write_q      <= 1'b0;
         size_q       <= 3'b000;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && any_req) begin
            grant_q <= win;
            write_q <= win ? bus.write1 : bus.write0;
            size_q  <= win ? bus.size1  : bus.size0;
            addr_q  <= win ? bus.addr1  : bus.addr0;
            wdata_q <= win ? bus.wdata1 : bus.wdata0;
         end
         if (state_q == RESP)
            last_grant_q <= grant_q;
      end
   end

   assign bus.ahbsram_req   = (state_q == ISSUE);
   assign bus.ahbsram_write = write_q;
   assign bus.ahbsram_size  = size_q;
   assign bus.ahbsram_addr  = addr_q;
   assign bus.ahbsram_wdata = wdata_q;

   // Acks and read data are decoded from the registered state, so they cannot overlap.
   assign bus.ack0   = (state_q == RESP) && !grant_q;
   assign bus.ack1   = (state_q == RESP) &&  grant_q;
   assign bus.rdata0 = (bus.ack0 && !write_q) ? bus.sramahb_rdata : 32'h0;
   assign bus.rdata1 = (bus.ack1 && !write_q) ? bus.sramahb_rdata : 32'h0;

   assign grant    = grant_q;
   assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a one-cycle-latency SRAM responder.
// Expectations follow SRAM_ARB_FIXED_PRIO_EN when it is defined.
module tb_sram_req_arbiter;
   localparam int AW = 19;

   logic        HCLK = 1'b0;
   logic        aresetn;
   logic        grant;
   logic        arb_busy;
   logic        auto_ack;
   logic        spur_ack;
   logic        resp_ack = 1'b0;
   logic [31:0] model_rdata;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_ack0;
   int          n_ack1;
   logic        exp_g;

   sram_req_arbiter_if #(.MEM_AWIDTH(AW)) bus ();

   sram_req_arbiter #(.MEM_AWIDTH(AW)) dut (
      .HCLK     (HCLK),
      .aresetn  (aresetn),
      .bus      (bus),
      .grant    (grant),
      .arb_busy (arb_busy)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) resp_ack <= auto_ack & bus.ahbsram_req;
   assign bus.sramahb_ack   = resp_ack | spur_ack;
   assign bus.sramahb_rdata = model_rdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      aresetn = 1'b0;
      auto_ack = 1'b1;
      spur_ack = 1'b0;
      model_rdata = 32'hDEADBEEF;
      bus.req0 = 0; bus.req1 = 0; bus.write0 = 0; bus.write1 = 0;
      bus.size0 = 0; bus.size1 = 0; bus.addr0 = '0; bus.addr1 = '0;
      bus.wdata0 = 0; bus.wdata1 = 0;
      step(); step();
      check("rst_ack0", bus.ack0, 0);
      check("rst_ack1", bus.ack1, 0);
      check("rst_req", bus.ahbsram_req, 0);
      check("rst_addr", bus.ahbsram_addr, 0);
      check("rst_grant", grant, 0);
      check("rst_busy", arb_busy, 0);
      aresetn = 1'b1;
      step();

      // single read, port 0
      bus.req0 = 1; bus.write0 = 0; bus.size0 = 3'b010; bus.addr0 = 19'h0010;
      step();
      check("rd0_issue_req", bus.ahbsram_req, 1);
      check("rd0_issue_addr", bus.ahbsram_addr, 19'h0010);
      check("rd0_issue_write", bus.ahbsram_write, 0);
      check("rd0_issue_size", bus.ahbsram_size, 3'b010);
      check("rd0_grant", grant, 0);
      check("rd0_busy", arb_busy, 1);
      bus.req0 = 0;
      step();
      check("rd0_wait_req", bus.ahbsram_req, 0);
      check("rd0_wait_ack0", bus.ack0, 0);
      step();
      check("rd0_ack0", bus.ack0, 1);
      check("rd0_rdata0", bus.rdata0, 32'hDEADBEEF);
      check("rd0_ack1", bus.ack1, 0);
      check("rd0_rdata1", bus.rdata1, 0);
      step();
      check("rd0_ack0_done", bus.ack0, 0);
      check("rd0_idle_busy", arb_busy, 0);

      // single write, port 1; rdata must stay 0 even with live SRAM data
      model_rdata = 32'h12345678;
      bus.req1 = 1; bus.write1 = 1; bus.size1 = 3'b000; bus.addr1 = 19'h0103; bus.wdata1 = 32'hA5;
      step();
      check("wr1_addr", bus.ahbsram_addr, 19'h0103);
      check("wr1_size", bus.ahbsram_size, 3'b000);
      check("wr1_write", bus.ahbsram_write, 1);
      check("wr1_wdata", bus.ahbsram_wdata, 32'hA5);
      check("wr1_grant", grant, 1);
      bus.req1 = 0; bus.addr1 = 19'h7FFFF; bus.write1 = 0; bus.wdata1 = 32'hFFFF_FFFF;
      step();
      check("wr1_wait_addr", bus.ahbsram_addr, 19'h0103);
      check("wr1_wait_write", bus.ahbsram_write, 1);
      check("wr1_wait_wdata", bus.ahbsram_wdata, 32'hA5);
      step();
      check("wr1_ack1", bus.ack1, 1);
      check("wr1_ack0", bus.ack0, 0);
      check("wr1_rdata1", bus.rdata1, 0);
      step();

      // request dropped before it is sampled
      bus.req0 = 1;
      @(negedge HCLK);
      bus.req0 = 0;
      step();
      check("drop_busy", arb_busy, 0);
      check("drop_req", bus.ahbsram_req, 0);

      // both ports held: 4 transactions in 16 cycles
      bus.req0 = 1; bus.req1 = 1; bus.write0 = 0; bus.write1 = 0;
      n_ack0 = 0; n_ack1 = 0;
      for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         exp_g = 1'b0;
`else
         exp_g = i[0];
`endif
         step();
         check($sformatf("both_grant%0d", i), grant, exp_g);
         step(); step();
         check($sformatf("both_ack%0d", i), exp_g ? bus.ack1 : bus.ack0, 1);
         if (bus.ack0) n_ack0++;
         if (bus.ack1) n_ack1++;
         step();
         check($sformatf("both_idle%0d", i), arb_busy, 0);
      end
`ifdef SRAM_ARB_FIXED_PRIO_EN
      check("both_n_ack0", n_ack0, 4);
      check("both_n_ack1", n_ack1, 0);
`else
      check("both_n_ack0", n_ack0, 2);
      check("both_n_ack1", n_ack1, 2);
`endif
      bus.req0 = 0; bus.req1 = 0;
      step();

      // command inputs change while waiting; latched address must hold
      auto_ack = 0;
      model_rdata = 32'h0BADF00D;
      bus.req0 = 1; bus.write0 = 0; bus.addr0 = 19'h20;
      step();
      bus.req0 = 0;
      step();
      bus.addr0 = 19'h40;
      step();
      check("hold_wait_addr", bus.ahbsram_addr, 19'h20);
      check("hold_wait_busy", arb_busy, 1);
      spur_ack = 1;
      step();
      spur_ack = 0;
      check("hold_resp_addr", bus.ahbsram_addr, 19'h20);
      check("hold_resp_ack0", bus.ack0, 1);
      check("hold_resp_rdata0", bus.rdata0, 32'h0BADF00D);
      step();

      // reset while in WAIT
      bus.req0 = 1; bus.write0 = 1; bus.addr0 = 19'h50; bus.wdata0 = 32'h11;
      step();
      bus.req0 = 0;
      step();
      check("rstw_busy_before", arb_busy, 1);
      aresetn = 0;
      #1;
      check("rstw_busy", arb_busy, 0);
      check("rstw_addr", bus.ahbsram_addr, 0);
      check("rstw_write", bus.ahbsram_write, 0);
      check("rstw_wdata", bus.ahbsram_wdata, 0);
      check("rstw_grant", grant, 0);
      step();
      check("rstw_ack0", bus.ack0, 0);
      aresetn = 1; auto_ack = 1;
      model_rdata = 32'hCAFEF00D;
      bus.req0 = 1; bus.req1 = 1; bus.write0 = 0; bus.addr0 = 19'h60;
      step();
      check("rstw_first_grant", grant, 0);
      check("rstw_first_addr", bus.ahbsram_addr, 19'h60);
      bus.req0 = 0; bus.req1 = 0;
      step(); step();
      check("rstw_first_ack0", bus.ack0, 1);
      check("rstw_first_ack1", bus.ack1, 0);
      check("rstw_first_rdata0", bus.rdata0, 32'hCAFEF00D);
      step();

      // spurious downstream ack while idle
      spur_ack = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("spur_ack0_%0d", i), bus.ack0, 0);
         check($sformatf("spur_ack1_%0d", i), bus.ack1, 0);
         check($sformatf("spur_busy_%0d", i), arb_busy, 0);
      end
      spur_ack = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the AHB-Lite LSRAM control interface (req/write/size/addr/wdata -> ack/rdata).
- Lets a second master (e.g. bootloader/UART bridge loader) share the SRAM with the AHB slave path.
- Arbitrates, latches the winner's command, issues a single-cycle request downstream, waits for ack, then returns ack and read data to the winner.

Parameters:
- MEM_AWIDTH, 19, byte-address width of requester and downstream addresses.
- (fixed) data width 32, not parameterised.

Ports:
- HCLK  in  1  clock, all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  request level per port; held until matching ack
- write0 / write1  in  1  1 = write, 0 = read
- size0 / size1  in  3  AHB HSIZE encoding (000 byte, 001 half, 010 word)
- addr0 / addr1  in  MEM_AWIDTH  byte address
- wdata0 / wdata1  in  32  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  32  read data, valid only with ack on a read
- ahbsram_req  out  1  downstream request, single-cycle pulse
- ahbsram_write  out  1  latched write flag
- ahbsram_size  out  3  latched size
- ahbsram_addr  out  MEM_AWIDTH  latched address
- ahbsram_wdata  out  32  latched write data
- sramahb_ack  in  1  downstream completion
- sramahb_rdata  in  32  downstream registered read data
- grant  out  1  index of current or last granted port
- arb_busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (aresetn low, async):
  - state = IDLE; ack0/1 = 0; ahbsram_req = 0; latched write/size/addr/wdata = 0.
  - grant = 0; last_grant = 1, so port 0 wins the first contention; arb_busy = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any reqN is high, select a winner and register grant.
  - Latch writeN/sizeN/addrN/wdataN into the downstream registers, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - ahbsram_req = 1 for exactly this cycle, with latched command stable; go to WAIT.
- WAIT:
  - ahbsram_req = 0; latched command held stable.
  - On sramahb_ack = 1, go to RESP; otherwise stay.
  - No timeout.
- RESP:
  - ack[grant] = 1 for one cycle.
  - If the latched op is a read, rdata[grant] = sramahb_rdata; otherwise 0.
  - last_grant <= grant; go to IDLE.
- Data/ack outputs:
  - rdata outputs are 0 except the granted port's in RESP on a read.
  - ack0 and ack1 are never high together.
- Selection (default, round-robin):
  - One requester pending: grant it.
  - Both pending: grant the port != last_grant.
- Latency:
  - Request sampled in IDLE at cycle T.
  - ahbsram_req at T+1, sramahb_ack expected at T+2, ackN at T+3.
  - Minimum 4 cycles per transaction; a continuously held req0 alone gives one ack per 4 cycles.
- Requester rule:
  - reqN still high in the cycle after ackN counts as a new request.
  - Requester command inputs may change after grant; the arbiter uses only latched values.
- Request dropped before grant: ignored, nothing issued. Dropped after grant: the transaction still completes and ackN still pulses.
- A new request arriving during ISSUE/WAIT/RESP waits until IDLE; no queue beyond req levels.
- sramahb_ack outside WAIT: ignored.
- Reset mid-transaction: immediate return to IDLE, no ack generated; the downstream controller shares aresetn.

Optional Feature:
- SRAM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, port 0 always wins contention; last_grant still updated but unused for selection.
  - Undefined: round-robin as above.

Test Plan:
- Single read port 0, addr0=0x0010, model returns 0xDEADBEEF:
  - ahbsram_req pulse 1 cycle after req0, ack0 3 cycles after sample.
  - rdata0=0xDEADBEEF, ack1=0, rdata1=0.
- Single write port 1, addr1=0x0103, size1=000, wdata1=0x000000A5:
  - ahbsram_addr=0x0103, size=000, write=1 latched through WAIT; ack1 pulses; rdata1=0.
- req0 and req1 both asserted and held from reset:
  - Grants alternate 0,1,0,1 (4 cycles each), 4 acks in 16 cycles.
  - With SRAM_ARB_FIXED_PRIO_EN: port 0 only, port 1 starved while req0 held.
- Port 0 changes addr0 from 0x20 to 0x40 in WAIT -> ahbsram_addr stays 0x20 until RESP.
- aresetn asserted during WAIT -> outputs at reset values immediately, no ack; after release, a fresh req0 completes normally with port 0 granted first.
- Spurious sramahb_ack in IDLE with no requests -> no ack0/ack1, state stays IDLE, arb_busy=0.
